// File: rtl/cic_dec_ctrl.sv
// Run-time decimation-factor controller for the CIC decimator: validates and applies new
// factors on frame boundaries, flushes and warms up the CIC, and counts arithmetic events.
module cic_dec_ctrl #(
  parameter int unsigned DEC_WIDTH    = 4,
  parameter int unsigned Q            = 1,
  parameter int unsigned N            = 1,
  parameter int unsigned DEFAULT_DEC  = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [DEC_WIDTH:0]   cfg_dec,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 cfg_done,
  output logic                 busy,
  input  logic                 valid_in,
  output logic                 cic_valid_in,
  output logic [DEC_WIDTH:0]   cic_dec_factor,
  output logic                 cic_rst_n,
  input  logic                 cic_valid_out,
  input  logic                 cic_overflow,
  input  logic                 cic_underflow,
  output logic                 out_valid,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] udf_cnt
);

  localparam int unsigned FW   = DEC_WIDTH + 1;
  localparam int unsigned WARM = Q * N;
  localparam int unsigned WW   = (WARM > 1) ? $clog2(WARM) : 1;
  localparam int unsigned FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, SETTLE} state_t;

  state_t         state;
  logic [FW-1:0]  phase;
  logic [FW-1:0]  pending;
  logic [FW-1:0]  last_phase;
  logic [FCW-1:0] flush_cnt;
  logic [WW-1:0]  warm_cnt;
  logic           mask;
  logic           cfg_legal;
  logic           boundary;

  assign last_phase   = cic_dec_factor - FW'(1);
  // Legal factors are the powers of two up to 2**DEC_WIDTH; the port width excludes larger ones.
  assign cfg_legal    = (cfg_dec != '0) && ((cfg_dec & (cfg_dec - FW'(1))) == '0);
  assign boundary     = (state == DRAIN) && valid_in && (phase == last_phase);
  assign cic_valid_in = valid_in && (state != FLUSH);
  assign out_valid    = cic_valid_out && !mask;

  // Phase mirrors the CIC's own decimation counter so the frame boundary is known here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (state == FLUSH) begin
      phase <= '0;
    end else if (cic_valid_in) begin
      phase <= (phase >= last_phase) ? '0 : phase + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      pending        <= FW'(DEFAULT_DEC);
      cic_dec_factor <= FW'(DEFAULT_DEC);
      cic_rst_n      <= 1'b0;
      cfg_ready      <= 1'b1;
      cfg_err        <= 1'b0;
      cfg_done       <= 1'b0;
      busy           <= 1'b0;
      mask           <= 1'b0;
      flush_cnt      <= '0;
      warm_cnt       <= '0;
    end else begin
      cfg_err  <= 1'b0;
      cfg_done <= 1'b0;
      case (state)
        RUN: begin
          cic_rst_n <= 1'b1;
          if (cfg_valid) begin
            if (cfg_legal) begin
              pending   <= cfg_dec;
              state     <= DRAIN;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (boundary) begin
            state          <= FLUSH;
            cic_rst_n      <= 1'b0;
            cic_dec_factor <= pending;
            mask           <= 1'b1;
            flush_cnt      <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) begin
            state     <= SETTLE;
            cic_rst_n <= 1'b1;
            warm_cnt  <= '0;
          end else begin
            flush_cnt <= flush_cnt + FCW'(1);
          end
        end
        SETTLE: begin
          if (cic_valid_out) begin
            if (warm_cnt == WW'(WARM - 1)) begin
              state     <= RUN;
              mask      <= 1'b0;
              cfg_done  <= 1'b1;
              cfg_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt + WW'(1);
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Clear has priority over a coincident event; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (out_valid && cic_overflow && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
      if (out_valid && cic_underflow && (udf_cnt != '1))
        udf_cnt <= udf_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: cfg_err/cfg_done pulses go through a scoreboard queue,
// timing and counter behaviour are checked inline against hand-computed values.
module tb_cic_dec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [4:0]  cfg_dec;
  logic        cfg_ready, cfg_err, cfg_done, busy;
  logic        valid_in, cic_valid_in, cic_rst_n;
  logic [4:0]  cic_dec_factor;
  logic        cic_valid_out, cic_overflow, cic_underflow, out_valid, clr_cnt;
  logic [15:0] ovf_cnt, udf_cnt;

  logic        n_cfg_ready, n_cfg_err, n_cfg_done, n_busy, n_cic_valid_in, n_cic_rst_n, n_out_valid;
  logic [4:0]  n_cic_dec_factor;
  logic [3:0]  n_ovf_cnt, n_udf_cnt;

  typedef struct packed {
    logic       is_done;
    logic [4:0] dec;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cic_dec_ctrl #(.DEC_WIDTH(4), .Q(1), .N(1), .DEFAULT_DEC(1), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_dec(cfg_dec), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .cfg_done(cfg_done), .busy(busy), .valid_in(valid_in),
    .cic_valid_in(cic_valid_in), .cic_dec_factor(cic_dec_factor), .cic_rst_n(cic_rst_n),
    .cic_valid_out(cic_valid_out), .cic_overflow(cic_overflow), .cic_underflow(cic_underflow),
    .out_valid(out_valid), .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  cic_dec_ctrl #(.DEC_WIDTH(4), .Q(1), .N(1), .DEFAULT_DEC(1), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_dec(cfg_dec), .cfg_ready(n_cfg_ready),
    .cfg_err(n_cfg_err), .cfg_done(n_cfg_done), .busy(n_busy), .valid_in(valid_in),
    .cic_valid_in(n_cic_valid_in), .cic_dec_factor(n_cic_dec_factor), .cic_rst_n(n_cic_rst_n),
    .cic_valid_out(cic_valid_out), .cic_overflow(cic_overflow), .cic_underflow(cic_underflow),
    .out_valid(n_out_valid), .clr_cnt(clr_cnt), .ovf_cnt(n_ovf_cnt), .udf_cnt(n_udf_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cfg_err / cfg_done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (cfg_err || cfg_done)) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got err=%0b done=%0b expected no pulse at %0t", cfg_err, cfg_done, $time);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_done !== cfg_done || mon_e.is_done === cfg_err || mon_e.dec !== cic_dec_factor) begin
          n_fail++;
          $display("FAIL sb_pulse: got done=%0b err=%0b dec=%0d expected done=%0b dec=%0d at %0t",
                   cfg_done, cfg_err, cic_dec_factor, mon_e.is_done, mon_e.dec, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int passed;
    logic [4:0] bad [3];
    bad[0] = 5'd3; bad[1] = 5'd0; bad[2] = 5'd17;
    rst = 1'b1; cfg_valid = 1'b0; cfg_dec = '0; valid_in = 1'b0;
    cic_valid_out = 1'b0; cic_overflow = 1'b0; cic_underflow = 1'b0; clr_cnt = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_dec_factor", cic_dec_factor, 1);
    chk("rst_cic_rst_n", cic_rst_n, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1 chk("rel_cic_rst_n_low", cic_rst_n, 0);
    tick();
    chk("rel_cic_rst_n_high", cic_rst_n, 1);

    // Illegal factors
    foreach (bad[i]) begin
      cfg_valid = 1'b1; cfg_dec = bad[i];
      sb_q.push_back('{is_done: 1'b0, dec: 5'd1});
      tick();
      chk("ill_err_pulse", cfg_err, 1);
      chk("ill_busy", busy, 0);
      chk("ill_ready", cfg_ready, 1);
      cfg_valid = 1'b0;
      tick();
      chk("ill_err_clear", cfg_err, 0);
      chk("ill_dec_unchanged", cic_dec_factor, 1);
    end

    // Legal reconfiguration 1 -> 4, valid_in held high
    valid_in = 1'b1; cfg_valid = 1'b1; cfg_dec = 5'd4;
    sb_q.push_back('{is_done: 1'b1, dec: 5'd4});
    tick();
    cfg_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", cfg_ready, 0);
    chk("t1_drain_pass", cic_valid_in, 1);
    tick();
    chk("t1_flush_rst_n", cic_rst_n, 0);
    chk("t1_flush_dec", cic_dec_factor, 4);
    chk("t1_flush_gate", cic_valid_in, 0);
    tick();
    chk("t1_flush2_rst_n", cic_rst_n, 0);
    tick();
    chk("t1_settle_rst_n", cic_rst_n, 1);
    chk("t1_settle_pass", cic_valid_in, 1);
    valid_in = 1'b0; cic_valid_out = 1'b1; cic_overflow = 1'b1;
    #1 chk("t1_masked_out", out_valid, 0);
    tick();
    cic_valid_out = 1'b0; cic_overflow = 1'b0;
    chk("t1_done_ready", cfg_ready, 1);
    chk("t1_done_busy", busy, 0);
    chk("t1_masked_ovf", ovf_cnt, 0);

    // 4 -> 8: FLUSH must follow the phase-3 sample; second request during SETTLE ignored
    valid_in = 1'b1; cfg_valid = 1'b1; cfg_dec = 5'd8;
    sb_q.push_back('{is_done: 1'b1, dec: 5'd8});
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t4_drain_rst_n", cic_rst_n, 1);
    end
    chk("t4_drain_dec", cic_dec_factor, 4);
    tick();
    chk("t4_phase3_flush", cic_rst_n, 0);
    chk("t4_flush_dec", cic_dec_factor, 8);
    valid_in = 1'b0;
    tick(); tick();
    chk("t4_settle", cic_rst_n, 1);
    cfg_valid = 1'b1; cfg_dec = 5'd2;
    chk("t4_busy_ready", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    chk("t4_still_busy", busy, 1);
    cic_valid_out = 1'b1;
    tick();
    cic_valid_out = 1'b0;
    tick(); tick();
    chk("t4_ignored_dec", cic_dec_factor, 8);
    chk("t4_ignored_busy", busy, 0);

    // Sparse input: 8 -> 2, valid_in every third cycle
    cfg_valid = 1'b1; cfg_dec = 5'd2;
    sb_q.push_back('{is_done: 1'b1, dec: 5'd2});
    tick();
    cfg_valid = 1'b0;
    s = 0; passed = 0;
    for (int c = 0; c < 60 && s < 8; c++) begin
      valid_in = (c % 3 == 2);
      #1 if (cic_valid_in) passed++;
      tick();
      if (valid_in) s++;
      if (s < 8) chk("t3_drain_hold", cic_rst_n, 1);
    end
    valid_in = 1'b0;
    chk("t3_samples_passed", passed, 8);
    chk("t3_boundary_flush", cic_rst_n, 0);
    chk("t3_flush_dec", cic_dec_factor, 2);
    tick(); tick();
    cic_valid_out = 1'b1;
    tick();
    cic_valid_out = 1'b0;
    tick();

    // Counters
    cic_valid_out = 1'b1; cic_overflow = 1'b1;
    #1 chk("t5_unmasked_out", out_valid, 1);
    for (int k = 0; k < 5; k++) tick();
    cic_overflow = 1'b0; cic_underflow = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    cic_valid_out = 1'b0; cic_underflow = 1'b0;
    chk("t5_ovf5", ovf_cnt, 5);
    chk("t5_udf3", udf_cnt, 3);
    clr_cnt = 1'b1; cic_valid_out = 1'b1; cic_overflow = 1'b1;
    tick();
    clr_cnt = 1'b0;
    cic_valid_out = 1'b0; cic_overflow = 1'b0;
    chk("t5_clr_ovf", ovf_cnt, 0);
    chk("t5_clr_udf", udf_cnt, 0);
    cic_valid_out = 1'b1; cic_overflow = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    cic_valid_out = 1'b0; cic_overflow = 1'b0;
    chk("t5_ovf20", ovf_cnt, 20);
    chk("t5_sat15", n_ovf_cnt, 15);

    // Reset during FLUSH: 2 -> 4 aborted
    valid_in = 1'b1; cfg_valid = 1'b1; cfg_dec = 5'd4;
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("t6_in_flush", cic_rst_n, 0);
    chk("t6_flush_dec", cic_dec_factor, 4);
    rst = 1'b1;
    #1;
    chk("t6_rst_dec", cic_dec_factor, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    valid_in = 1'b0;
    tick();
    rst = 1'b0;
    #1 chk("t6_rel_rst_n_low", cic_rst_n, 0);
    tick();
    chk("t6_rel_rst_n_high", cic_rst_n, 1);
    chk("t6_run", busy, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
